// File: rtl/seq_mult_8.sv
// 8x8 unsigned shift-and-add multiplier: one partial product per cycle for 8 cycles,
// valid/ready handshake on both sides, product held until the next result.
module seq_mult_8 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [15:0] acc_q, acc_d;
    logic [2:0]  count_q, count_d;
    logic [15:0] product_q, product_d;

    logic [15:0] add_sum;
    logic [15:0] acc_next;

    CLA_16 u_cla (
        .a   (acc_q),
        .b   (mcand_q),
        .cin (1'b0),
        .sum (add_sum)
    );

    // Add the shifted multiplicand only when the current multiplier bit is set.
    assign acc_next = mplier_q[0] ? add_sum : acc_q;

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign product   = product_q;

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        count_d   = count_q;
        product_d = product_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    mcand_d  = {8'h00, a};
                    mplier_d = b;
                    acc_d    = 16'h0000;
                    count_d  = 3'd0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 3'd1;
                // Always run all eight steps, even for zero operands.
                if (count_q == 3'd7) begin
                    product_d = acc_next;
                    state_d   = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            mcand_q   <= 16'h0000;
            mplier_q  <= 8'h00;
            acc_q     <= 16'h0000;
            count_q   <= 3'd0;
            product_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

endmodule

// 16-bit carry-lookahead adder: four 4-bit lookahead groups with a second lookahead level
// across the group generate/propagate terms. No carry-out.
module CLA_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum
);

    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] c;
    logic [3:0]  gp;
    logic [3:0]  gg;
    logic [3:0]  gc;

    assign p = a ^ b;
    assign g = a & b;

    for (genvar k = 0; k < 4; k++) begin : g_grp
        assign gp[k] = &p[4*k +: 4];
        assign gg[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);

        assign c[4*k]   = gc[k];
        assign c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
        assign c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
        assign c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                        | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end

    // Group carries are fully expanded so no group waits on its neighbour's carry.
    assign gc[0] = cin;
    assign gc[1] = gg[0] | (gp[0] & cin);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & cin);

    assign sum = p ^ c;

endmodule

// File: tb/tb_seq_mult_8.sv
// Scoreboard bench for seq_mult_8: expected products queued at accept, popped on handshake,
// plus latency, initiation-interval, hold and reset-abandon checks.
module tb_seq_mult_8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;

    logic        rand_mode = 1'b0;
    logic        rand_rdy  = 1'b1;
    logic        fix_rdy   = 1'b1;
    logic        chk_ii    = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ov_rises = 0;

    typedef struct {
        logic [15:0] exp;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    assign out_ready = rand_mode ? rand_rdy : fix_rdy;

    seq_mult_8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rand_rdy = ($urandom_range(0, 2) != 0);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    logic        prev_ov   = 1'b0;
    logic        prev_ir   = 1'b1;
    logic [15:0] prev_prod = 16'h0000;
    int          low_cnt   = 0;
    int          last_acc  = 0;
    logic        last_ii   = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            low_cnt = 0;
            last_ii = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                ov_rises++;
                if (sb.size() != 0) check_eq("latency", cyc - sb[0].cyc, 9);
            end
            if (out_valid && prev_ov) check_eq("hold", product, prev_prod);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("sb_unexpected", product, 32'hDEAD_BEEF);
                end else begin
                    check_eq("product", product, sb[0].exp);
                    void'(sb.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                if (chk_ii && last_ii) check_eq("ii", cyc - last_acc, 10);
                sb.push_back('{exp: 16'(a) * 16'(b), cyc: cyc});
                last_acc = cyc;
                last_ii  = chk_ii;
            end
            if (!in_ready) begin
                low_cnt++;
            end else begin
                if (!prev_ir && chk_ii && last_ii) check_eq("ready_low", low_cnt, 9);
                low_cnt = 0;
            end
        end
        prev_ov   = out_valid;
        prev_ir   = in_ready;
        prev_prod = product;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse(input string tag);
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 8'hA5;
        b        = 8'h5A;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        check_eq({tag, "_in_ready"}, in_ready, 1);
        check_eq({tag, "_out_valid"}, out_valid, 0);
        check_eq({tag, "_product"}, product, 0);
    endtask

    task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b);
        int n = 0;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        if (!in_ready) check_eq("wait_ready_timeout", 0, 1);
        a        = op_a;
        b        = op_b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 30) begin
            step();
            n++;
        end
        if (!out_valid) check_eq("wait_valid_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 400) begin
            step();
            n++;
        end
        check_eq("drain", sb.size(), 0);
    endtask

    int rises0;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
        step();
        step();
        reset_pulse("reset");

        // 0xFF * 0xFF with a 3-cycle output stall.
        fix_rdy = 1'b0;
        run_op(8'hFF, 8'hFF);
        wait_out();
        for (int i = 0; i < 3; i++) begin
            check_eq("stall_valid", out_valid, 1);
            check_eq("stall_prod", product, 16'hFE01);
            step();
        end
        fix_rdy = 1'b1;
        check_eq("stall_valid", out_valid, 1);
        step();
        check_eq("post_idle", in_ready, 1);
        check_eq("post_valid", out_valid, 0);
        check_eq("post_keep", product, 16'hFE01);

        // Zero operands still take the full run.
        run_op(8'h0D, 8'h00);
        drain();
        run_op(8'h00, 8'hC8);
        check_eq("run_keep", product, 16'h0000);
        drain();

        // Back-to-back with in_valid held and operands churning.
        chk_ii   = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 42; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            step();
        end
        in_valid = 1'b0;
        drain();
        chk_ii = 1'b0;

        // Reset abandons a run in its 4th cycle.
        rises0 = ov_rises;
        run_op(8'h12, 8'h34);
        step();
        step();
        step();
        reset_pulse("run_reset");
        for (int i = 0; i < 12; i++) step();
        check_eq("no_pulse", ov_rises, rises0);
        run_op(8'h03, 8'h05);
        drain();
        check_eq("after_abandon", product, 16'h000F);

        // Reset from DONE.
        fix_rdy = 1'b0;
        run_op(8'h21, 8'h43);
        wait_out();
        reset_pulse("done_reset");
        fix_rdy = 1'b1;
        step();
        check_eq("done_reset_valid", out_valid, 0);

        // Random operands with random output stalls.
        rand_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            run_op(8'($urandom), 8'($urandom));
        end
        drain();
        rand_mode = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_mult_8.md
SEQ_MULT_8 -- requirements
Module: seq_mult_8

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 8x8 unsigned operands and a 16-bit product.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operands a/b are presented.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  8  multiplicand, unsigned.
REQ-008 b  input  8  multiplier, unsigned.
REQ-009 out_valid  output  1  product is valid.
REQ-010 out_ready  input  1  consumer accepts the product.
REQ-011 product  output  16  unsigned a*b, registered.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE: in_ready=1 and out_valid=0; an accept occurs when in_valid=1 on a clock edge.
REQ-014 On accept: mcand<=zero-extended a (16 bits), mplier<=b, acc<=0, count<=0, and the state goes to RUN.
REQ-015 RUN: in_ready=0 and out_valid=0; a, b and in_valid SHALL be ignored.
REQ-016 RUN, each cycle: acc<=acc+mcand if mplier[0]=1, otherwise acc holds; mcand<=mcand<<1; mplier<=mplier>>1; count<=count+1.
REQ-017 The acc+mcand sum SHALL come from the codebase 16-bit carry-lookahead adder CLA_16, with carry-in 0 and no carry-out.
REQ-018 Adder arithmetic is modulo 2^16; overflow cannot occur (255*255=65025).
REQ-019 RUN SHALL last exactly 8 cycles, with no early termination for zero operands.
REQ-020 At the edge ending the RUN cycle with count=7, the final acc value SHALL load the product register and the state SHALL go to DONE.
REQ-021 Latency: for an accept at the edge ending cycle T, out_valid SHALL first be high in cycle T+9.
REQ-022 DONE: out_valid=1, in_ready=0, and product SHALL be held stable.
REQ-023 DONE: when out_ready=1 on an edge, the state SHALL go to IDLE; otherwise it stays in DONE indefinitely.
REQ-024 DONE with in_valid=1 and out_ready=1: no accept occurs in that cycle; the earliest next accept is the following IDLE cycle.
REQ-025 Minimum initiation interval SHALL be 10 cycles.
REQ-026 product SHALL keep the last result through IDLE and RUN until the next DONE load.
REQ-027 in_ready SHALL be a pure decode of state (IDLE).
REQ-028 out_valid SHALL be a pure decode of state (DONE).

Reset
REQ-029 When rst=1 on an edge, the next state SHALL be IDLE, overriding all other inputs.
REQ-030 The same edge SHALL clear product, acc, mcand, mplier and count to 0.
REQ-031 After reset: in_ready=1, out_valid=0, product=16'h0000.
REQ-032 Reset in RUN or DONE SHALL abandon the operation with no out_valid pulse.
REQ-033 An in_valid present in the reset cycle SHALL NOT be accepted.

Verification
REQ-034 rst high for 1 cycle, from any state -> next cycle: in_ready=1, out_valid=0, product=0x0000.
REQ-035 a=0xFF, b=0xFF accepted at T, out_ready held 0 for 3 cycles -> out_valid rises in T+9; product=0xFE01 stable for 4 cycles; IDLE after the out_ready edge.
REQ-036 a=0x0D, b=0x00 -> product 0x0000 at T+9; then a=0x00, b=0xC8 -> 0x0000 at T+9, proving no early exit.
REQ-037 in_valid held 1, out_ready held 1, operands changed every cycle during RUN -> in_ready low for 9 cycles per op; consecutive accepts exactly 10 cycles apart; product equals the accept-time operands.
REQ-038 a=0x12, b=0x34 with rst pulsed in the 4th RUN cycle -> no out_valid; then a=0x03, b=0x05 -> product 0x000F.
REQ-039 1000 random operand pairs with random out_ready stalls -> every product equals a*b, in order, none dropped or duplicated.
